// File: rtl/return_pkg.sv
// Shared types, default UPC masks and the saturating-increment helper for the return station.
package return_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } station_state_t;

    localparam logic [7:0] DEF_DISC_MASK   = 8'hEC;
    localparam logic [7:0] DEF_STOLEN_MASK = 8'h10;

    localparam int unsigned SAT_W = 32;

    // Adds one when add is set, holding at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] value,
        input logic             add,
        input logic [SAT_W-1:0] max_val
    );
        if (add && (value != max_val)) begin
            return value + SAT_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/upc_classifier.sv
// Combinational UPC lookup: discount and theft-eligibility flags from mask tables.
module upc_classifier
    import return_pkg::*;
#(
    parameter int unsigned          UPC_W       = 3,
    parameter logic [2**UPC_W-1:0]  DISC_MASK   = DEF_DISC_MASK,
    parameter logic [2**UPC_W-1:0]  STOLEN_MASK = DEF_STOLEN_MASK
) (
    input  logic [UPC_W-1:0] upc,
    input  logic             mark,
    output logic             disc,
    output logic             stolen
);

    // Marked items are never treated as stolen.
    assign disc   = DISC_MASK[upc];
    assign stolen = STOLEN_MASK[upc] & ~mark;

endmodule

// File: rtl/return_station_ctrl.sv
// Streaming return station: classifies items, keeps saturating tallies, locks the lane on theft runs.
module return_station_ctrl
    import return_pkg::*;
#(
    parameter int unsigned          UPC_W        = 3,
    parameter logic [2**UPC_W-1:0]  DISC_MASK    = DEF_DISC_MASK,
    parameter logic [2**UPC_W-1:0]  STOLEN_MASK  = DEF_STOLEN_MASK,
    parameter int unsigned          CNT_W        = 8,
    parameter int unsigned          STOLEN_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UPC_W-1:0] in_upc,
    input  logic             in_mark,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_discount,
    output logic             out_stolen,
    output logic             alarm,
    input  logic             alarm_ack,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_disc,
    output logic [CNT_W-1:0] cnt_stolen
);

    localparam int unsigned      CS_W      = 4;
    localparam logic [0:0]       ST_RUN    = 1'(RUN);
    localparam logic [0:0]       ST_LOCKED = 1'(LOCKED);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic [CS_W-1:0] cs;
    logic [CS_W-1:0] cs_inc;
    logic            cls_disc;
    logic            cls_stolen;
    logic            accept;
    logic            lock_hit;

    upc_classifier #(
        .UPC_W       (UPC_W),
        .DISC_MASK   (DISC_MASK),
        .STOLEN_MASK (STOLEN_MASK)
    ) u_classifier (
        .upc    (in_upc),
        .mark   (in_mark),
        .disc   (cls_disc),
        .stolen (cls_stolen)
    );

    // Ready only in RUN and when the output slot is free or draining this cycle.
    assign in_ready = (state == ST_RUN) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign cs_inc   = cs + CS_W'(1);
    assign lock_hit = accept & cls_stolen & (cs_inc == CS_W'(STOLEN_LIMIT));
    assign alarm    = (state == ST_LOCKED);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: lock on the accept that completes a theft run, unlock on operator ack.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (lock_hit)  state_next = ST_LOCKED;
            ST_LOCKED: if (alarm_ack) state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // Consecutive-stolen counter; cleared by a clean accept or by unlocking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs <= '0;
        end else if (accept) begin
            cs <= cls_stolen ? cs_inc : '0;
        end else if ((state == ST_LOCKED) && alarm_ack) begin
            cs <= '0;
        end
    end

    // Output register: load on accept, hold while stalled, empty once consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_discount <= 1'b0;
            out_stolen   <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_discount <= cls_disc;
            out_stolen   <= cls_stolen;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Saturating tallies; clear takes priority over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!reset_n || clear_counts) begin
            cnt_total  <= '0;
            cnt_disc   <= '0;
            cnt_stolen <= '0;
        end else if (accept) begin
            cnt_total  <= CNT_W'(sat_inc(SAT_W'(cnt_total),  1'b1,       SAT_W'(CNT_MAX)));
            cnt_disc   <= CNT_W'(sat_inc(SAT_W'(cnt_disc),   cls_disc,   SAT_W'(CNT_MAX)));
            cnt_stolen <= CNT_W'(sat_inc(SAT_W'(cnt_stolen), cls_stolen, SAT_W'(CNT_MAX)));
        end
    end

endmodule

// File: tb/tb_return_station_ctrl.sv
// Randomised scoreboard bench for return_station_ctrl with a behavioural reference model.
module tb_return_station_ctrl;

    localparam int LIMIT   = 3;
    localparam int CNT_CAP = 255;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_upc = 3'd0;
    logic       in_mark = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_discount;
    logic       out_stolen;
    logic       alarm;
    logic       alarm_ack = 1'b0;
    logic       clear_counts = 1'b0;
    logic [7:0] cnt_total;
    logic [7:0] cnt_disc;
    logic [7:0] cnt_stolen;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    int  mode     = 0;
    bit  auto_ack = 1'b0;
    bit  auto_clr = 1'b0;
    bit  end_req  = 1'b0;

    return_station_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_upc       (in_upc),
        .in_mark      (in_mark),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_discount (out_discount),
        .out_stolen   (out_stolen),
        .alarm        (alarm),
        .alarm_ack    (alarm_ack),
        .clear_counts (clear_counts),
        .cnt_total    (cnt_total),
        .cnt_disc     (cnt_disc),
        .cnt_stolen   (cnt_stolen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference classification from the bit-level rules, code = {U,P,C}.
    function automatic logic [1:0] ref_class(input logic [2:0] upc, input logic mark);
        logic u, p, c;
        u = upc[2]; p = upc[1]; c = upc[0];
        return {p | (u & c), u & ~p & ~c & ~mark};
    endfunction

    // Reference model: checks registered state, then predicts the coming clock edge.
    initial begin : model
        bit m_ovalid, m_locked, ready_m, acc, end_done;
        int m_cs, m_tot, m_disc, m_stol;
        logic [1:0] cls;
        m_ovalid = 0; m_locked = 0; m_cs = 0; m_tot = 0; m_disc = 0; m_stol = 0;
        end_done = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_ovalid = 0; m_locked = 0; m_cs = 0;
                m_tot = 0; m_disc = 0; m_stol = 0;
                exp_q.delete();
            end else begin
                ready_m = !m_locked && (!m_ovalid || out_ready);
                check("in_ready",   int'(in_ready),   int'(ready_m));
                check("alarm",      int'(alarm),      int'(m_locked));
                check("out_valid",  int'(out_valid),  int'(m_ovalid));
                check("cnt_total",  int'(cnt_total),  m_tot);
                check("cnt_disc",   int'(cnt_disc),   m_disc);
                check("cnt_stolen", int'(cnt_stolen), m_stol);
                if (end_req && !end_done) begin
                    check("drain_queue_empty", exp_q.size(), 0);
                    end_done = 1;
                end
                acc = in_valid && ready_m;
                cls = ref_class(in_upc, in_mark);
                if (acc) exp_q.push_back(cls);
                if (acc) m_ovalid = 1;
                else if (out_ready) m_ovalid = 0;
                if (clear_counts) begin
                    m_tot = 0; m_disc = 0; m_stol = 0;
                end else if (acc) begin
                    if (m_tot < CNT_CAP) m_tot++;
                    if (cls[1] && m_disc < CNT_CAP) m_disc++;
                    if (cls[0] && m_stol < CNT_CAP) m_stol++;
                end
                if (acc) begin
                    m_cs = cls[0] ? m_cs + 1 : 0;
                    if (m_cs == LIMIT) m_locked = 1;
                end else if (m_locked && alarm_ack) begin
                    m_locked = 0;
                    m_cs = 0;
                end
            end
        end
    end

    // Monitor: compares every presented result against the head of the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL result_unexpected actual=%0d required=none at %0t",
                             {out_discount, out_stolen}, $time);
                end else begin
                    check("result", int'({out_discount, out_stolen}), int'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        alarm_ack    = auto_ack && ($urandom_range(0, 3) == 0);
        clear_counts = auto_clr && ($urandom_range(0, 31) == 0);
    endtask

    // Presents one item and holds it until the station takes it.
    task automatic send_item(input logic [2:0] upc, input logic mark);
        bit taken;
        int n;
        in_valid = 1'b1;
        in_upc   = upc;
        in_mark  = mark;
        taken    = 0;
        n        = 0;
        while (!taken) begin
            @(negedge clk);
            taken = in_ready;
            tick();
            n++;
            if (n > 300) begin
                $display("FAIL handshake_timeout actual=%0d required=accept", n);
                $fatal(1, "stimulus stalled");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin : stimulus
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Sweep all codes, unmarked then marked.
        mode = 0;
        for (int m = 0; m < 2; m++)
            for (int u = 0; u < 8; u++) send_item(3'(u), 1'(m));
        idle(2);

        // Stall: first result must hold while later items wait.
        mode = 2;
        idle(1);
        send_item(3'd5, 1'b0);
        fork
            send_item(3'd2, 1'b0);
            begin repeat (4) @(posedge clk); mode = 0; end
        join
        send_item(3'd3, 1'b1);
        idle(2);

        // Three stolen in a row lock the lane; ack unlocks.
        for (int i = 0; i < 3; i++) send_item(3'd4, 1'b0);
        in_valid = 1'b1; in_upc = 3'd1; in_mark = 1'b0;
        repeat (3) tick();
        alarm_ack = 1'b1;
        @(posedge clk); #1;
        alarm_ack = 1'b0;
        repeat (2) tick();
        in_valid = 1'b0;
        send_item(3'd6, 1'b0);

        // A clean item breaks the run.
        send_item(3'd4, 1'b0);
        send_item(3'd4, 1'b0);
        send_item(3'd4, 1'b1);
        send_item(3'd4, 1'b0);
        send_item(3'd4, 1'b0);
        idle(2);
        alarm_ack = 1'b1;
        tick();

        // Saturate total and discount tallies, then clear alongside an accept.
        for (int i = 0; i < 270; i++) send_item(3'd7, 1'b0);
        clear_counts = 1'b1;
        send_item(3'd4, 1'b1);
        idle(2);

        // Random traffic with random back-pressure, acks and clears.
        mode = 1; auto_ack = 1'b1; auto_clr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_item(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
        end
        mode = 0; auto_ack = 1'b0; auto_clr = 1'b0;
        idle(3);
        alarm_ack = 1'b1;
        tick();
        idle(2);

        // Reset while locked with a result pending.
        send_item(3'd4, 1'b0);
        send_item(3'd4, 1'b0);
        idle(2);
        mode = 2;
        idle(1);
        send_item(3'd4, 1'b0);
        idle(1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle(3);

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
